// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus between the PC/loader logic and the if_stage.
//   master : drives fetch enable/PC and the instruction-memory write port,
//            observes the registered IF/ID outputs.
//   slave  : the if_stage side of the same signals.
//   i_enable      fetch enable (0 = stall)
//   i_pc          word address to fetch
//   i_write       instruction-memory write strobe
//   i_address     word address for the write
//   i_instruction data to write
//   o_instruction fetched instruction (registered)
//   o_pc          i_pc + 1 (registered)
interface if_stage_if #(
    parameter int NB_INST = 32,
    parameter int NB_ADDR = 32
);
    logic               i_enable;
    logic [NB_ADDR-1:0] i_pc;
    logic               i_write;
    logic [NB_ADDR-1:0] i_address;
    logic [NB_INST-1:0] i_instruction;
    logic [NB_INST-1:0] o_instruction;
    logic [NB_ADDR-1:0] o_pc;

    modport master (
        output i_enable, i_pc, i_write, i_address, i_instruction,
        input  o_instruction, o_pc
    );

    modport slave (
        input  i_enable, i_pc, i_write, i_address, i_instruction,
        output o_instruction, o_pc
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage with a writable word-addressed instruction memory.
//   i_clk   rising-edge clock
//   i_reset asynchronous active-low reset; clears outputs and every memory word
//   bus     if_stage_if slave: fetch enable/PC, memory write port, IF/ID outputs
module if_stage #(
    parameter int NB_INST   = 32,
    parameter int NB_ADDR   = 32,
    parameter int MEM_DEPTH = 64
) (
    input logic         i_clk,
    input logic         i_reset,
    if_stage_if.slave   bus
);
    localparam int NB_IDX = $clog2(MEM_DEPTH);

    logic [NB_INST-1:0] mem [MEM_DEPTH];
    logic [NB_IDX-1:0]  rd_idx;
    logic [NB_IDX-1:0]  wr_idx;
    logic [NB_INST-1:0] instruction_q;
    logic [NB_ADDR-1:0] pc_q;

    // Truncating casts keep only the low index bits, so addresses wrap modulo MEM_DEPTH.
    assign rd_idx = NB_IDX'(bus.i_pc);
    assign wr_idx = NB_IDX'(bus.i_address);

    // Writes ignore i_enable so the program can be loaded while the stage is stalled.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < MEM_DEPTH; k++)
                mem[k] <= '0;
        end else if (bus.i_write) begin
            mem[wr_idx] <= bus.i_instruction;
        end
    end

    // The read samples mem before this edge's write lands: same-index fetch sees the old word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            instruction_q <= '0;
            pc_q          <= '0;
        end else if (bus.i_enable) begin
            instruction_q <= mem[rd_idx];
            pc_q          <= bus.i_pc + NB_ADDR'(1);
        end
    end

    assign bus.o_instruction = instruction_q;
    assign bus.o_pc          = pc_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
module tb_if_stage;
    localparam int NB_INST   = 32;
    localparam int NB_ADDR   = 32;
    localparam int MEM_DEPTH = 64;

    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    if_stage_if #(.NB_INST(NB_INST), .NB_ADDR(NB_ADDR)) bus ();

    if_stage #(.NB_INST(NB_INST), .NB_ADDR(NB_ADDR), .MEM_DEPTH(MEM_DEPTH)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] pc, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.i_enable      = en;
        bus.i_pc          = pc;
        bus.i_write       = wr;
        bus.i_address     = addr;
        bus.i_instruction = data;
        @(negedge i_clk);
    endtask

    initial begin
        // Reset held with random inputs
        bus.i_enable      = 1'b1;
        bus.i_pc          = $urandom;
        bus.i_write       = 1'b1;
        bus.i_address     = $urandom;
        bus.i_instruction = $urandom;
        repeat (3) @(negedge i_clk);
        chk("rst_instr", bus.o_instruction, 32'h0);
        chk("rst_pc", bus.o_pc, 32'h0);
        i_reset = 1'b1;
        drive(1, 32'd5, 0, 0, 0);
        chk("post_rst_instr", bus.o_instruction, 32'h0);
        chk("post_rst_pc", bus.o_pc, 32'd6);

        // Load and fetch
        drive(0, 0, 1, 32'd1, 32'h00223021);
        drive(0, 0, 1, 32'd2, 32'h00433024);
        chk("stall_hold_pc", bus.o_pc, 32'd6);
        drive(1, 32'd1, 0, 0, 0);
        chk("fetch1_instr", bus.o_instruction, 32'h00223021);
        chk("fetch1_pc", bus.o_pc, 32'd2);
        drive(1, 32'd2, 0, 0, 0);
        chk("fetch2_instr", bus.o_instruction, 32'h00433024);
        chk("fetch2_pc", bus.o_pc, 32'd3);

        // Overwrite and read-before-write
        drive(0, 0, 1, 32'd2, 32'h002430C0);
        drive(1, 32'd2, 0, 0, 0);
        chk("overwrite_instr", bus.o_instruction, 32'h002430C0);
        drive(1, 32'd2, 1, 32'd2, 32'h11111111);
        chk("rbw_old", bus.o_instruction, 32'h002430C0);
        drive(1, 32'd2, 0, 0, 0);
        chk("rbw_new", bus.o_instruction, 32'h11111111);

        // Write and fetch of different indices in one edge
        drive(1, 32'd1, 1, 32'd7, 32'h22334455);
        chk("diff_fetch", bus.o_instruction, 32'h00223021);
        drive(1, 32'd7, 0, 0, 0);
        chk("diff_write", bus.o_instruction, 32'h22334455);
        chk("diff_pc", bus.o_pc, 32'd8);

        // Stall: outputs hold while pc changes and memory is written
        drive(0, 32'd1, 1, 32'd1, 32'hAAAA5555);
        drive(0, 32'd9, 0, 0, 0);
        chk("stall_instr", bus.o_instruction, 32'h22334455);
        chk("stall_pc", bus.o_pc, 32'd8);
        drive(1, 32'd1, 0, 0, 0);
        chk("reen_instr", bus.o_instruction, 32'hAAAA5555);
        chk("reen_pc", bus.o_pc, 32'd2);

        // Address wrap
        drive(0, 0, 1, MEM_DEPTH + 3, 32'h08000001);
        drive(1, 32'd3, 0, 0, 0);
        chk("wrap_instr", bus.o_instruction, 32'h08000001);
        chk("wrap_pc", bus.o_pc, 32'd4);
        drive(1, 32'd67, 0, 0, 0);
        chk("wrap_fetch_hi", bus.o_instruction, 32'h08000001);
        drive(1, 32'hFFFFFFFF, 0, 0, 0);
        chk("pc_wrap", bus.o_pc, 32'h0);
        chk("pc_wrap_instr", bus.o_instruction, 32'h0);

        // Async reset between edges
        drive(1, 32'd1, 0, 0, 0);
        chk("pre_arst_instr", bus.o_instruction, 32'hAAAA5555);
        #2 i_reset = 1'b0;
        #1;
        chk("arst_instr", bus.o_instruction, 32'h0);
        chk("arst_pc", bus.o_pc, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b1;
        drive(1, 32'd1, 0, 0, 0);
        chk("arst_mem1", bus.o_instruction, 32'h0);
        drive(1, 32'd3, 0, 0, 0);
        chk("arst_mem3", bus.o_instruction, 32'h0);
        chk("arst_pc_after", bus.o_pc, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
